// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: next-PC select, freeze/flush decode and end-of-program halt.
// Define FETCH_CTRL_PERF_EN to build the saturating stall_count performance counter.
module fetch_ctrl #(
  parameter logic [31:0] END_ADDR    = 32'd164,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_cur,
  input  logic                   hazard,
  input  logic                   mem_ready,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  output logic [31:0]            pc_next,
  output logic                   pc_freeze,
  output logic                   flush_if_id,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_START;
    else      state_q <= state_d;
  end

  // Branches win over stalls; an accepted PC beyond END_ADDR stops fetch for good.
  always_comb begin
    state_d     = state_q;
    pc_freeze   = 1'b1;
    flush_if_id = 1'b0;
    pc_next     = branch_taken ? branch_addr : (pc_cur + 32'd4);
    active      = (state_q == S_RUN) || (state_q == S_STALL);

    case (state_q)
      S_START: state_d = S_RUN;
      S_RUN, S_STALL: begin
        if (branch_taken) begin
          pc_freeze   = 1'b0;
          flush_if_id = 1'b1;
          state_d     = S_RUN;
        end else if (hazard || !mem_ready) begin
          pc_freeze = 1'b1;
          state_d   = S_STALL;
        end else begin
          pc_freeze = 1'b0;
          state_d   = S_RUN;
        end
        if (!pc_freeze && (pc_next > END_ADDR)) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign halted = (state_q == S_HALT);

`ifdef FETCH_CTRL_PERF_EN
  logic [STALL_CNT_W-1:0] stall_count_q;

  // Counts frozen cycles while fetching; START and HALT are excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= '0;
    end else if (active && pc_freeze && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule
